mux8x1_rr_collector: RTL and testbench
======================================

Name: mux8x1_rr_collector

Overview:
- 8-into-1 collector, the inverse of the 8-way demultiplexer. It merges eight 8-bit source channels onto one registered output stream.
- Each output beat carries the data byte and the 3-bit index (endereco) of the source channel it came from. A downstream demux can therefore route it back.
- Arbitration is round-robin, or fixed-priority when selected by `modo`. All channels use valid/ready handshakes.
- Throughput is one beat per cycle. Latency is one cycle, through a single output register.

Parameters:
- WIDTH, 8, data width of every channel and of the output.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous reset, active-low
- modo  input  1  0 = round-robin, 1 = fixed priority (channel 0 highest)
- in_valid  input  8  per-channel valid; bit i belongs to channel i
- in_ready  output  8  per-channel ready; one-hot or zero
- in_dados  input  8*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream ready
- out_dados  output  WIDTH  selected data
- out_endereco  output  3  source channel index of out_dados

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_dados=0, out_endereco=0.
  - Internal pointer ptr=7, so the first round-robin search starts at channel 0.
  - in_ready=0 while rst_n is low.
- Definitions:
  - load = ~out_valid | out_ready (the output register is free or is being drained this cycle).
  - any = |in_valid.
- Selection (combinational):
  - modo=0: sel = first i with in_valid[i]=1, searching ptr+1, ptr+2, ... modulo 8 (wraps 7 to 0).
  - modo=1: sel = lowest i with in_valid[i]=1; ptr is ignored for selection.
- in_ready[sel] = load & any. All other in_ready bits are 0. in_ready is never asserted for a channel whose in_valid is 0.
- Channel i transfers when in_valid[i] & in_ready[i]. The source must hold in_valid and in_dados stable until that transfer.
- Clock edge, when load=1:
  - out_valid <= any.
  - If any: out_dados <= the data of channel sel, out_endereco <= sel, ptr <= sel. ptr updates in both modes.
- Clock edge, when load=0 (out_valid=1, out_ready=0):
  - out_valid, out_dados, out_endereco and ptr hold.
  - No in_ready is asserted.
- When load=1 and any=0: out_valid drops to 0; out_dados and out_endereco keep their old values (don't-care).
- Simultaneous drain and refill (out_valid=1, out_ready=1, any=1): the new beat is loaded in the same edge, with no bubble. Sustained throughput is 1 beat per clock.
- Round-robin fairness: a channel holding in_valid continuously is granted within 8 grants.
- modo may change on any cycle. It affects only the next selection; a beat already held in the output register is unaffected.
- Reset mid-operation: a held output beat is discarded. No in_ready pulse is issued during reset, so no input beat is lost.
- out_valid never depends combinationally on out_ready. in_ready may depend combinationally on in_valid, out_valid and out_ready.

Test Plan:
- Reset then idle: rst_n low → out_valid=0, out_dados=0, out_endereco=0, in_ready=0. Release reset with in_valid=0 → everything stays 0.
- Single channel: in_valid=8'b0000_0100, channel 2 data=8'hA5, out_ready=1 → in_ready=8'b0000_0100 in that cycle. Next cycle out_valid=1, out_dados=8'hA5, out_endereco=3'd2.
- Round-robin wrap: modo=0, in_valid=8'hFF held, out_ready=1, channel i data=8'h10+i → out_endereco sequence 0,1,2,...,7,0,1 on consecutive cycles, with out_dados matching.
- Fixed priority: modo=1, in_valid=8'b1000_0011 held → out_endereco stays 0 every cycle. Drop in_valid[0] → selection moves to 1. Then drop in_valid[1] → selection moves to 7.
- Backpressure: output holding 8'h3C from channel 5, out_ready=0 for 4 cycles with in_valid=8'hFF → in_ready=0 throughout and the output is stable. Raise out_ready → 8'h3C is consumed and channel 6 is loaded on the same edge (modo=0).
- Async reset mid-stream: assert rst_n low between clock edges while out_valid=1 → out_valid=0 immediately. After release, the first round-robin grant goes to the lowest valid channel starting from 0.

Source files
------------

// File: rtl/mux8x1_rr_collector.sv
// 8-into-1 collector with round-robin / fixed-priority arbitration.
// Merges eight valid/ready source channels onto one registered output beat.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active-low
//   modo         0 = round-robin, 1 = fixed priority (channel 0 highest)
//   in_valid     per-channel valid, bit i = channel i
//   in_ready     per-channel ready, one-hot or zero
//   in_dados     channel i data at [i*WIDTH +: WIDTH]
//   out_valid    output beat valid (registered)
//   out_ready    downstream ready
//   out_dados    data of the held beat
//   out_endereco source channel index of the held beat
module mux8x1_rr_collector #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               modo,
    input  logic [7:0]         in_valid,
    output logic [7:0]         in_ready,
    input  logic [8*WIDTH-1:0] in_dados,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_dados,
    output logic [2:0]         out_endereco
);

    logic [2:0] ptr;
    logic [2:0] sel_rr;
    logic [2:0] sel_fp;
    logic [2:0] sel;
    logic [2:0] rr_idx;
    logic       rr_found;
    logic       load;
    logic       any;
    logic [WIDTH-1:0] sel_dados;

    // Output register is free, or its beat leaves on this edge.
    assign load = ~out_valid | out_ready;
    assign any  = |in_valid;

    // Round-robin: scan ptr+1 .. ptr+8 (mod 8); ptr itself is checked last.
    always_comb begin
        sel_rr   = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k <= 8; k++) begin
            rr_idx = ptr + 3'(k);
            if (!rr_found && in_valid[rr_idx]) begin
                rr_found = 1'b1;
                sel_rr   = rr_idx;
            end
        end
    end

    // Fixed priority: lowest index wins, so scan downwards.
    always_comb begin
        sel_fp = '0;
        for (int i = 7; i >= 0; i--) begin
            if (in_valid[i]) begin
                sel_fp = 3'(i);
            end
        end
    end

    assign sel = modo ? sel_fp : sel_rr;

    assign sel_dados = in_dados[sel*WIDTH +: WIDTH];

    // Grant only the selected channel; gated by rst_n so no beat is
    // accepted (and lost) while the output register is held in reset.
    always_comb begin
        in_ready = '0;
        if (rst_n && load && any) begin
            in_ready = 8'(1) << sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_dados    <= '0;
            out_endereco <= '0;
            ptr          <= 3'd7;
        end else if (load) begin
            out_valid <= any;
            if (any) begin
                out_dados    <= sel_dados;
                out_endereco <= sel;
                ptr          <= sel;
            end
        end
    end

endmodule

// File: tb/tb_mux8x1_rr_collector.sv
// Directed self-checking bench for mux8x1_rr_collector.
// One task per scenario, each with its own inline comparisons.
module tb_mux8x1_rr_collector;

    logic        clk;
    logic        rst_n;
    logic        modo;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic [63:0] in_dados;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_dados;
    logic [2:0]  out_endereco;

    int pass_cnt = 0;
    int total    = 0;

    mux8x1_rr_collector #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .modo         (modo),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dados     (in_dados),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_dados    (out_dados),
        .out_endereco (out_endereco)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse reset between edges; returns at posedge+1 with in_valid=0.
    task automatic do_reset();
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        modo      = 1'b0;
        in_valid  = '0;
        in_dados  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL reset_valid got=%0b exp=0", out_valid);
        else pass_cnt++;
        total++;
        if (out_dados !== 8'h00)
            $display("FAIL reset_dados got=%h exp=00", out_dados);
        else pass_cnt++;
        total++;
        if (out_endereco !== 3'd0)
            $display("FAIL reset_endereco got=%0d exp=0", out_endereco);
        else pass_cnt++;
        total++;
        if (in_ready !== 8'h00)
            $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        else pass_cnt++;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 8'h00)
            $display("FAIL idle_after_reset got v=%0b r=%b exp v=0 r=0",
                     out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_single();
        in_valid          = 8'b0000_0100;
        in_dados[16 +: 8] = 8'hA5;
        out_ready         = 1'b1;
        #1;
        total++;
        if (in_ready !== 8'b0000_0100)
            $display("FAIL single_in_ready got=%b exp=00000100", in_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || out_dados !== 8'hA5 || out_endereco !== 3'd2)
            $display("FAIL single_out got v=%0b d=%h e=%0d exp v=1 d=a5 e=2",
                     out_valid, out_dados, out_endereco);
        else pass_cnt++;
        in_valid = '0;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || out_dados !== 8'hA5)
            $display("FAIL single_drain got v=%0b d=%h exp v=0 d=a5",
                     out_valid, out_dados);
        else pass_cnt++;
    endtask

    task automatic test_rr_wrap();
        logic [2:0] e;
        do_reset();
        modo      = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            in_dados[i*8 +: 8] = 8'h10 + 8'(i);
        in_valid = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            e = 3'(k % 8);
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || out_endereco !== e ||
                out_dados !== 8'h10 + 8'(e))
                $display("FAIL rr_wrap[%0d] got v=%0b e=%0d d=%h exp v=1 e=%0d d=%h",
                         k, out_valid, out_endereco, out_dados, e, 8'h10 + 8'(e));
            else pass_cnt++;
        end
    endtask

    task automatic test_fixed();
        modo     = 1'b1;
        in_valid = 8'b1000_0011;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_endereco !== 3'd0 || out_dados !== 8'h10)
                $display("FAIL fixed_ch0[%0d] got e=%0d d=%h exp e=0 d=10",
                         k, out_endereco, out_dados);
            else pass_cnt++;
        end
        in_valid = 8'b1000_0010;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_endereco !== 3'd1)
                $display("FAIL fixed_ch1[%0d] got e=%0d exp e=1", k, out_endereco);
            else pass_cnt++;
        end
        in_valid = 8'b1000_0000;
        @(posedge clk);
        #1;
        total++;
        if (out_endereco !== 3'd7 || out_dados !== 8'h17)
            $display("FAIL fixed_ch7 got e=%0d d=%h exp e=7 d=17",
                     out_endereco, out_dados);
        else pass_cnt++;
        modo = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        modo              = 1'b0;
        in_dados[40 +: 8] = 8'h3C;
        in_dados[48 +: 8] = 8'h66;
        in_valid          = 8'b0010_0000;
        out_ready         = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_endereco !== 3'd5 || out_dados !== 8'h3C)
            $display("FAIL bp_load got e=%0d d=%h exp e=5 d=3c",
                     out_endereco, out_dados);
        else pass_cnt++;
        out_ready = 1'b0;
        in_valid  = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (in_ready !== 8'h00)
                $display("FAIL bp_in_ready[%0d] got=%b exp=0", k, in_ready);
            else pass_cnt++;
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || out_dados !== 8'h3C || out_endereco !== 3'd5)
                $display("FAIL bp_hold[%0d] got v=%0b d=%h e=%0d exp v=1 d=3c e=5",
                         k, out_valid, out_dados, out_endereco);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 8'b0100_0000)
            $display("FAIL bp_release_ready got=%b exp=01000000", in_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || out_endereco !== 3'd6 || out_dados !== 8'h66)
            $display("FAIL bp_refill got v=%0b e=%0d d=%h exp v=1 e=6 d=66",
                     out_valid, out_endereco, out_dados);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        modo      = 1'b0;
        out_ready = 1'b1;
        in_valid  = 8'hFF;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1)
            $display("FAIL ar_pre got v=%0b exp v=1", out_valid);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 8'h00 || out_endereco !== 3'd0)
            $display("FAIL ar_assert got v=%0b r=%b e=%0d exp v=0 r=0 e=0",
                     out_valid, in_ready, out_endereco);
        else pass_cnt++;
        in_valid = 8'b0001_1000;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || out_endereco !== 3'd3 || out_dados !== 8'h13)
            $display("FAIL ar_first_grant got v=%0b e=%0d d=%h exp v=1 e=3 d=13",
                     out_valid, out_endereco, out_dados);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total++;
        if (out_endereco !== 3'd4 || out_dados !== 8'h14)
            $display("FAIL ar_second_grant got e=%0d d=%h exp e=4 d=14",
                     out_endereco, out_dados);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_wrap();
        test_fixed();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
